sort4_seq: RTL and testbench

//   Sequential sorter for four N-bit operands, ascending (s0 smallest).

---
 rtl/sort4_seq.sv | 143 ++++++++++++++
 tb/tb_sort4_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sort4_seq.sv
// Sequential ascending sorter for four N-bit operands.
// One shared comparator, one compare-and-swap per clock, 6-step bubble network.
module sort4_seq #(
  parameter int N      = 6,
  parameter bit SIGNED = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x0,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] x2,
  input  logic [N-1:0] x3,
  output logic [N-1:0] s0,
  output logic [N-1:0] s1,
  output logic [N-1:0] s2,
  output logic [N-1:0] s3,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_C01A,
    S_C12A,
    S_C23,
    S_C01B,
    S_C12B,
    S_C01C,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [N-1:0] r_w [4];
  logic [N-1:0] r_s [4];
  logic         r_busy;
  logic         r_done;

  logic [1:0]   w_idx;
  logic         w_step;
  logic [N-1:0] w_cx;
  logic [N-1:0] w_cy;
  logic         w_gl;
  logic [N-1:0] w_n [4];

  // Pair select depends on the current state only.
  always_comb begin
    w_idx  = 2'd0;
    w_step = 1'b0;
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_C01A;
      S_C01A: begin
        w_idx  = 2'd0;
        w_step = 1'b1;
        w_next = S_C12A;
      end
      S_C12A: begin
        w_idx  = 2'd1;
        w_step = 1'b1;
        w_next = S_C23;
      end
      S_C23: begin
        w_idx  = 2'd2;
        w_step = 1'b1;
        w_next = S_C01B;
      end
      S_C01B: begin
        w_idx  = 2'd0;
        w_step = 1'b1;
        w_next = S_C12B;
      end
      S_C12B: begin
        w_idx  = 2'd1;
        w_step = 1'b1;
        w_next = S_C01C;
      end
      S_C01C: begin
        w_idx  = 2'd0;
        w_step = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_cx = r_w[w_idx];
  assign w_cy = r_w[w_idx + 2'd1];

  generate
    if (SIGNED) begin : g_sgn
      assign w_gl = $signed(w_cx) > $signed(w_cy);
    end else begin : g_uns
      assign w_gl = w_cx > w_cy;
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < 4; i++) w_n[i] = r_w[i];
    if (w_step && w_gl) begin
      w_n[w_idx]        = w_cy;
      w_n[w_idx + 2'd1] = w_cx;
    end
  end

  // Results load on the last swap so they are valid while done is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_w[i] <= '0;
        r_s[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      if (r_state == S_IDLE && start) begin
        r_w[0] <= x0;
        r_w[1] <= x1;
        r_w[2] <= x2;
        r_w[3] <= x3;
      end else if (w_step) begin
        for (int i = 0; i < 4; i++) r_w[i] <= w_n[i];
      end
      if (r_state == S_C01C) begin
        for (int i = 0; i < 4; i++) r_s[i] <= w_n[i];
      end
    end
  end

  assign s0   = r_s[0];
  assign s1   = r_s[1];
  assign s2   = r_s[2];
  assign s3   = r_s[3];
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_sort4_seq.sv
// Bench for sort4_seq: unsigned and signed instances, directed and random
// operand sets checked against a sort-by-key reference model.
module tb_sort4_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] x [4];
  logic [5:0] su [4];
  logic [5:0] ss [4];
  logic       busy_u, done_u, busy_s, done_s;

  int n_chk  = 0;
  int n_fail = 0;

  logic [5:0] exp_u [4];
  logic [5:0] exp_s [4];

  always #5 clk = ~clk;

  sort4_seq #(.N(6), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
    .s0(su[0]), .s1(su[1]), .s2(su[2]), .s3(su[3]),
    .busy(busy_u), .done(done_u)
  );

  sort4_seq #(.N(6), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
    .s0(ss[0]), .s1(ss[1]), .s2(ss[2]), .s3(ss[3]),
    .busy(busy_s), .done(done_s)
  );

  function automatic int key(input logic [5:0] v, input bit sgn);
    return sgn ? int'($signed(v)) : int'(v);
  endfunction

  // Reference: plain insertion sort on integer keys.
  function automatic void ref_sort(input logic [5:0] v [4], input bit sgn,
                                   output logic [5:0] o [4]);
    logic [5:0] t;
    for (int i = 0; i < 4; i++) o[i] = v[i];
    for (int i = 1; i < 4; i++)
      for (int j = i; j > 0; j--)
        if (key(o[j-1], sgn) > key(o[j], sgn)) begin
          t = o[j]; o[j] = o[j-1]; o[j-1] = t;
        end
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input logic [5:0] eu [4],
                       input logic [5:0] es [4]);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s u.s%0d", tag, i), int'(su[i]), int'(eu[i]));
      chk($sformatf("%s s.s%0d", tag, i), int'(ss[i]), int'(es[i]));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full sort with cycle-accurate busy/done/s checks.
  task automatic run(input string tag, input logic [5:0] a, b, c, d,
                     input bit mid_start, input bit start_in_done);
    logic [5:0] v [4];
    logic [5:0] pu [4];
    logic [5:0] ps [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      pu[i] = exp_u[i];
      ps[i] = exp_s[i];
      x[i]  = v[i];
    end
    ref_sort(v, 1'b0, exp_u);
    ref_sort(v, 1'b1, exp_s);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      chk($sformatf("%s busy c%0d", tag, j), int'(busy_u), 1);
      chk($sformatf("%s busy_s c%0d", tag, j), int'(busy_s), 1);
      chk($sformatf("%s done c%0d", tag, j), int'(done_u), int'(j == 7));
      chk($sformatf("%s done_s c%0d", tag, j), int'(done_s), int'(j == 7));
      if (j < 7) chk_s($sformatf("%s hold c%0d", tag, j), pu, ps);
      else       chk_s($sformatf("%s result", tag), exp_u, exp_s);
      if (mid_start && j == 2) begin
        start = 1'b1;
        for (int i = 0; i < 4; i++) x[i] = '0;
      end else begin
        start = (start_in_done && j == 7);
      end
      tick();
    end
    start = 1'b0;
    chk($sformatf("%s idle busy", tag), int'(busy_u | busy_s), 0);
    chk($sformatf("%s idle done", tag), int'(done_u | done_s), 0);
    chk_s($sformatf("%s after", tag), exp_u, exp_s);
    tick();
    chk($sformatf("%s idle2 busy", tag), int'(busy_u | busy_s), 0);
  endtask

  initial begin
    logic [5:0] zero [4];
    for (int i = 0; i < 4; i++) begin
      zero[i]  = '0;
      exp_u[i] = '0;
      exp_s[i] = '0;
      x[i]     = 6'h15;
    end
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    tick();
    chk("reset busy", int'(busy_u | busy_s), 0);
    chk("reset done", int'(done_u | done_s), 0);
    chk_s("reset", zero, zero);
    rst_n = 1'b1;
    start = 1'b0;
    tick();

    run("basic", 6'd5, 6'd3, 6'd7, 6'd1, 1'b0, 1'b0);
    chk("basic lit s0", int'(su[0]), 1);
    chk("basic lit s3", int'(su[3]), 7);
    run("order", 6'h3F, 6'd2, 6'h20, 6'd0, 1'b0, 1'b0);
    chk("order u.s3", int'(su[3]), 'h3F);
    chk("order s.s0", int'(ss[0]), 'h20);
    chk("order s.s1", int'(ss[1]), 'h3F);
    run("ties", 6'd4, 6'd4, 6'd4, 6'd4, 1'b0, 1'b0);
    run("worst", 6'd9, 6'd8, 6'd7, 6'd6, 1'b0, 1'b0);
    run("busy", 6'd11, 6'd30, 6'd1, 6'd17, 1'b1, 1'b0);
    run("b2b", 6'd40, 6'd33, 6'd50, 6'd2, 1'b0, 1'b1);

    // Reset during the C23 step discards the sort.
    x[0] = 6'd20; x[1] = 6'd10; x[2] = 6'd30; x[3] = 6'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_u[i] = '0;
      exp_s[i] = '0;
    end
    chk("midrst busy", int'(busy_u | busy_s), 0);
    chk("midrst done", int'(done_u | done_s), 0);
    chk_s("midrst", zero, zero);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("midrst nodone c%0d", j), int'(done_u | done_s), 0);
    end
    run("fresh", 6'd2, 6'd1, 6'd0, 6'd3, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++)
      run($sformatf("rnd%0d", k), 6'($urandom), 6'($urandom),
          6'($urandom), 6'($urandom), 1'($urandom), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
